imem_arbiter: RTL and testbench



---
 rtl/imem_arb_pkg.sv | 21 ++
 rtl/imem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_imem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and constants for the instruction-RAM arbiter.
package imem_arb_pkg;

    // Arbiter FSM: IDLE (nothing owned), ISSUE (owner locked, RAM busy),
    // WAIT (strobe accepted, waiting for the RAM acknowledge).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } imem_arb_state_t;

    // Requester that owns the current transfer.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LD = 1'b1
    } imem_arb_owner_t;

    // Byte enables used for every fetch and every loader read.
    localparam logic [3:0] IMEM_ARB_FULL_BE = 4'hF;

endpackage

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction RAM between the core
// fetch port and the debug/loader bus, one outstanding transfer at a time.
// Optional feature: define IMEM_ARB_AGING_EN to let a starved loader win the
// arbitration after p_starve_max lost rounds; otherwise fetch always wins.
//
// Handshake: each requester raises req with stable address/data and holds it
// until its one-cycle ack; the RAM takes a strobe in any cycle where
// i_mem_busy is low and answers with a one-cycle i_mem_ack one or more
// cycles later. o_dbg_state exposes the FSM state for observation.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int p_starve_max = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    // fetch port
    input  logic            i_if_req,
    input  logic [31:2]     i_if_addr,
    output logic [31:0]     o_if_rdata,
    output logic            o_if_ack,
    // loader port
    input  logic            i_ld_req,
    input  logic            i_ld_wr,
    input  logic [31:2]     i_ld_addr,
    input  logic [3:0]      i_ld_be,
    input  logic [31:0]     i_ld_wdata,
    output logic [31:0]     o_ld_rdata,
    output logic            o_ld_ack,
    // RAM request
    output logic [31:2]     o_mem_addr,
    output logic [3:0]      o_mem_be,
    output logic            o_mem_wr_en,
    output logic [31:0]     o_mem_wr_data,
    output logic            o_mem_rd_en,
    // RAM response
    input  logic [31:0]     i_mem_rd_data,
    input  logic            i_mem_busy,
    input  logic            i_mem_ack,
    // status
    output logic            o_ld_active,
    output imem_arb_state_t o_dbg_state
);

    imem_arb_state_t r_state;
    imem_arb_state_t w_next_state;
    imem_arb_owner_t r_owner;

    // Request captured at grant; replayed in ISSUE and held during WAIT.
    logic [31:2] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_wr;

    logic        w_any_req;
    logic        w_grant;
    logic        w_ld_wins;
    logic        w_force_ld;
    logic [31:2] w_req_addr;
    logic [3:0]  w_req_be;
    logic [31:0] w_req_wdata;
    logic        w_req_wr;

    assign w_any_req = i_if_req | i_ld_req;
    assign w_grant   = (r_state == IDLE) && w_any_req;
    assign w_ld_wins = i_ld_req && (!i_if_req || w_force_ld);

    // Winner's request as it would be presented to the RAM this cycle.
    assign w_req_wr    = w_ld_wins && i_ld_wr;
    assign w_req_addr  = w_ld_wins ? i_ld_addr : i_if_addr;
    assign w_req_be    = w_req_wr ? i_ld_be : IMEM_ARB_FULL_BE;
    assign w_req_wdata = w_ld_wins ? i_ld_wdata : r_wdata;

`ifdef IMEM_ARB_AGING_EN
    localparam int CNT_W = (p_starve_max < 1) ? 1 : $clog2(p_starve_max + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(p_starve_max);

    logic [CNT_W-1:0] r_starve;

    assign w_force_ld = (r_starve >= STARVE_MAX);

    // Count arbitrations the requesting loader loses; clear on a loader grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve <= '0;
        end else if (w_grant) begin
            if (w_ld_wins) begin
                r_starve <= '0;
            end else if (i_ld_req && (r_starve != STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_force_ld   = 1'b0;
    assign w_unused_cfg = (p_starve_max > 0);
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: grant in IDLE, stall in ISSUE, wait for the RAM ack.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next_state = i_mem_busy ? ISSUE : WAIT;
                end
            end
            ISSUE: begin
                if (!i_mem_busy) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (i_mem_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Owner and request capture at grant time.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
        end else if (w_grant) begin
            r_owner <= w_ld_wins ? OWN_LD : OWN_IF;
            r_addr  <= w_req_addr;
            r_be    <= w_req_be;
            r_wdata <= w_req_wdata;
            r_wr    <= w_req_wr;
        end
    end

    // Outputs: RAM strobes, ack/rdata routing to the owner, loader status.
    always_comb begin
        o_mem_addr    = r_addr;
        o_mem_be      = r_be;
        o_mem_wr_data = r_wdata;
        o_mem_wr_en   = 1'b0;
        o_mem_rd_en   = 1'b0;
        o_if_ack      = 1'b0;
        o_if_rdata    = '0;
        o_ld_ack      = 1'b0;
        o_ld_rdata    = '0;
        o_ld_active   = 1'b0;
        if (i_rst) begin
            o_mem_addr    = '0;
            o_mem_be      = '0;
            o_mem_wr_data = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        o_mem_addr    = w_req_addr;
                        o_mem_be      = w_req_be;
                        o_mem_wr_data = w_req_wdata;
                        o_mem_wr_en   = w_req_wr;
                        o_mem_rd_en   = !w_req_wr;
                        o_ld_active   = w_ld_wins;
                    end
                end
                ISSUE: begin
                    o_mem_wr_en = r_wr;
                    o_mem_rd_en = !r_wr;
                    o_ld_active = (r_owner == OWN_LD);
                end
                WAIT: begin
                    o_ld_active = (r_owner == OWN_LD);
                    if (i_mem_ack) begin
                        if (r_owner == OWN_LD) begin
                            o_ld_ack   = 1'b1;
                            o_ld_rdata = i_mem_rd_data;
                        end else begin
                            o_if_ack   = 1'b1;
                            o_if_rdata = i_mem_rd_data;
                        end
                    end
                end
                default: begin
                    o_mem_wr_en = 1'b0;
                end
            endcase
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed vectors, hand-written arbitration/busy/reset
// sequences and a randomized run against a transaction-level reference model.
// Follows the IMEM_ARB_AGING_EN setting of the build.
module tb_imem_arbiter;
    import imem_arb_pkg::*;

`ifdef IMEM_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif
    localparam int STARVE_MAX = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:2] if_addr = '0;
    logic        ld_req = 1'b0;
    logic        ld_wr = 1'b0;
    logic [31:2] ld_addr = '0;
    logic [3:0]  ld_be = '0;
    logic [31:0] ld_wdata = '0;
    logic        mem_busy = 1'b0;
    logic [31:0] if_rdata, ld_rdata, mem_wdata, mem_rdata;
    logic        if_ack, ld_ack, mem_wr_en, mem_rd_en, mem_ack, ld_active;
    logic [31:2] mem_addr;
    logic [3:0]  mem_be;
    imem_arb_state_t dbg_state;

    always #5 clk = ~clk;

    imem_arbiter #(.p_starve_max(STARVE_MAX)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ack(if_ack),
        .i_ld_req(ld_req), .i_ld_wr(ld_wr), .i_ld_addr(ld_addr), .i_ld_be(ld_be),
        .i_ld_wdata(ld_wdata), .o_ld_rdata(ld_rdata), .o_ld_ack(ld_ack),
        .o_mem_addr(mem_addr), .o_mem_be(mem_be), .o_mem_wr_en(mem_wr_en),
        .o_mem_wr_data(mem_wdata), .o_mem_rd_en(mem_rd_en),
        .i_mem_rd_data(mem_rdata), .i_mem_busy(mem_busy), .i_mem_ack(mem_ack),
        .o_ld_active(ld_active), .o_dbg_state(dbg_state)
    );

    // ---------------- RAM model (256 words, ack one cycle after accept) ----------------
    logic [31:0] ram_mem [0:255];
    logic        ram_ack = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic        ram_hold = 1'b0;
    logic        man_ack = 1'b0;
    logic        ram_clr = 1'b0;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    assign mem_ack   = ram_ack | man_ack;
    assign mem_rdata = ram_rdata;

    always @(posedge clk) begin
        ram_ack <= 1'b0;
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
        end else if (pre_we) begin
            ram_mem[pre_addr] <= pre_data;
        end else if (!ram_hold && !mem_busy && (mem_wr_en || mem_rd_en)) begin
            ram_ack   <= 1'b1;
            ram_rdata <= ram_mem[mem_addr[9:2]];
            if (mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; ld_req = 1'b0; mem_busy = 1'b0; man_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic ram_clear();
        @(negedge clk); ram_clr = 1'b1;
        @(negedge clk); ram_clr = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk); pre_we = 1'b0;
    endtask

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // ---------------- directed single-transfer vectors ----------------
    typedef struct {
        logic        is_ld;
        logic        wr;
        logic [31:2] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          busy_k;
        logic [31:0] exp_rd;
    } vec_t;

    // One transfer with busy held for busy_k cycles; ack expected at N+busy_k+1.
    task automatic run_xfer(input vec_t v, input string tag);
        int   cyc;
        logic got;
        logic is_wr;
        is_wr = v.is_ld && v.wr;
        @(negedge clk);
        if (v.is_ld) begin
            ld_req = 1'b1; ld_wr = v.wr; ld_addr = v.addr; ld_be = v.be; ld_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        mem_busy = (v.busy_k > 0);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc <= v.busy_k + 6) begin
            #1;
            if (cyc <= v.busy_k) begin
                chk({tag, " addr"}, 32'(mem_addr), 32'(v.addr));
                chk({tag, " be"}, 32'(mem_be), is_wr ? 32'(v.be) : 32'h0000000F);
                chk({tag, " wr_en"}, 32'(mem_wr_en), 32'(is_wr));
                chk({tag, " rd_en"}, 32'(mem_rd_en), 32'(!is_wr));
                chk({tag, " ld_active"}, 32'(ld_active), 32'(v.is_ld));
            end
            if (if_ack || ld_ack) begin
                got = 1'b1;
                chk({tag, " ack_cycle"}, 32'(cyc), 32'(v.busy_k + 1));
                chk({tag, " if_ack"}, 32'(if_ack), 32'(!v.is_ld));
                chk({tag, " ld_ack"}, 32'(ld_ack), 32'(v.is_ld));
                chk({tag, " strobes_low"}, 32'({mem_wr_en, mem_rd_en}), 32'h0);
                chk({tag, " addr_held"}, 32'(mem_addr), 32'(v.addr));
                if (!is_wr) chk({tag, " rdata"}, v.is_ld ? ld_rdata : if_rdata, v.exp_rd);
                if_req = 1'b0; ld_req = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
                mem_busy = (cyc < v.busy_k);
            end
        end
        if (!got) begin
            chk({tag, " ack_timeout"}, 32'h0, 32'h1);
            if_req = 1'b0; ld_req = 1'b0;
        end
        mem_busy = 1'b0;
    endtask

    vec_t vecs [9];

    // ---------------- randomized run with reference model ----------------
    logic [31:0] shadow [0:255];

    task automatic random_run(input int n_cycles);
        logic        have, accepted, m_ld, m_wr, ld_win;
        logic [31:2] m_addr;
        logic [3:0]  m_be;
        logic [31:0] m_wdata;
        int          starve;
        have = 1'b0; accepted = 1'b0; starve = 0;
        m_ld = 1'b0; m_wr = 1'b0; m_addr = '0; m_be = '0; m_wdata = '0;
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge clk);
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = 30'($urandom_range(0, 255));
            end
            if (!ld_req && $urandom_range(0, 2) == 0) begin
                ld_req = 1'b1; ld_wr = 1'($urandom_range(0, 1));
                ld_addr = 30'($urandom_range(0, 255));
                ld_be = 4'($urandom_range(0, 15)); ld_wdata = $urandom;
            end
            mem_busy = ($urandom_range(0, 3) == 0);
            #1;
            if (!have && (if_req || ld_req)) begin
                ld_win = ld_req && (!if_req || (AGING && starve >= STARVE_MAX));
                if (AGING) begin
                    if (ld_win) starve = 0;
                    else if (ld_req && starve < STARVE_MAX) starve++;
                end
                have = 1'b1; accepted = 1'b0; m_ld = ld_win;
                m_wr = ld_win && ld_wr;
                m_addr = ld_win ? ld_addr : if_addr;
                m_be = m_wr ? ld_be : 4'hF;
                m_wdata = ld_wdata;
            end
            if (have && !accepted) begin
                chk("rnd addr", 32'(mem_addr), 32'(m_addr));
                chk("rnd be", 32'(mem_be), 32'(m_be));
                chk("rnd strobes", 32'({mem_wr_en, mem_rd_en}), 32'({m_wr, !m_wr}));
                if (m_wr) chk("rnd wdata", mem_wdata, m_wdata);
                chk("rnd ack_early", 32'({if_ack, ld_ack}), 32'h0);
                chk("rnd ld_active", 32'(ld_active), 32'(m_ld));
                if (!mem_busy) accepted = 1'b1;
            end else if (have && accepted) begin
                chk("rnd wait_strobes", 32'({mem_wr_en, mem_rd_en}), 32'h0);
                chk("rnd acks", 32'({if_ack, ld_ack}), 32'({!m_ld, m_ld}));
                chk("rnd ld_active_wait", 32'(ld_active), 32'(m_ld));
                if (m_wr) begin
                    shadow[m_addr[9:2]] = merge_be(shadow[m_addr[9:2]], m_wdata, m_be);
                end else begin
                    chk("rnd rdata", m_ld ? ld_rdata : if_rdata, shadow[m_addr[9:2]]);
                end
                if (m_ld) ld_req = 1'b0;
                else if_req = 1'b0;
                have = 1'b0;
            end else begin
                chk("rnd idle_out", 32'({mem_wr_en, mem_rd_en, if_ack, ld_ack, ld_active}), 32'h0);
            end
        end
        // let the last transfer drain
        if_req = 1'b0; ld_req = 1'b0; mem_busy = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          n_acks;
        logic        who [$];
        logic        got;
        do_reset();
        ram_clear();
        #1;
        chk("reset if_ack", 32'(if_ack), 32'h0);
        chk("reset ld_ack", 32'(ld_ack), 32'h0);
        chk("reset strobes", 32'({mem_wr_en, mem_rd_en}), 32'h0);
        chk("reset mem_addr", 32'(mem_addr), 32'h0);
        chk("reset mem_be", 32'(mem_be), 32'h0);
        chk("reset ld_active", 32'(ld_active), 32'h0);
        chk("reset state", 32'(dbg_state), 32'(IDLE));

        preload(8'h40, 32'h00000013);
        preload(8'h20, 32'h11223344);

        //          is_ld wr    addr      be       wdata          busy exp_rd
        vecs[0] = '{1'b0, 1'b0, 30'h40, 4'h0,     32'h0,         0, 32'h00000013};
        vecs[1] = '{1'b1, 1'b1, 30'h10, 4'hF,     32'hDEADBEEF,  0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 30'h10, 4'h3,     32'h0,         0, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 30'h20, 4'b0010,  32'h0000AB00,  0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 30'h20, 4'h0,     32'h0,         0, 32'h1122AB44};
        vecs[5] = '{1'b0, 1'b0, 30'h10, 4'h0,     32'h0,         3, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 1'b1, 30'h30, 4'b1001,  32'hAABBCCDD,  2, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 30'h30, 4'h0,     32'h0,         3, 32'hAA0000DD};
        vecs[8] = '{1'b0, 1'b0, 30'h20, 4'h0,     32'h0,         1, 32'h1122AB44};
        for (int i = 0; i < 9; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // both requesters; fetch re-requests continuously
        do_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 30'h40;
        ld_req = 1'b1; ld_wr = 1'b0; ld_addr = 30'h10; ld_be = 4'h0;
        n_acks = 0;
        for (int c = 0; c < 60 && n_acks < 6; c++) begin
            #1;
            if (if_ack) begin who.push_back(1'b0); n_acks++; end
            if (ld_ack) begin who.push_back(1'b1); n_acks++; ld_req = 1'b0; end
            @(negedge clk);
        end
        chk("prio ack_count", 32'(who.size()), 32'd6);
        for (int i = 0; i < 6 && i < who.size(); i++)
            chk($sformatf("prio round%0d_is_ld", i), 32'(who[i]), 32'(AGING && i == STARVE_MAX));
        if_req = 1'b0;
        if (ld_req) begin
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                #1;
                if (ld_ack) begin
                    got = 1'b1;
                    chk("prio ld_rdata", ld_rdata, 32'hDEADBEEF);
                    ld_req = 1'b0;
                end
                @(negedge clk);
            end
            chk("prio ld_after_fetch", 32'(got), 32'h1);
            ld_req = 1'b0;
        end
        repeat (2) @(negedge clk);

        // reset in WAIT followed by a late RAM ack
        ram_hold = 1'b1;
        @(negedge clk);
        ld_req = 1'b1; ld_wr = 1'b0; ld_addr = 30'h20;
        @(negedge clk);
        #1;
        chk("rst_wait state", 32'(dbg_state), 32'(WAIT));
        chk("rst_wait strobes", 32'({mem_wr_en, mem_rd_en}), 32'h0);
        rst = 1'b1; ld_req = 1'b0;
        #1;
        chk("rst_wait outputs_in_reset", 32'({mem_wr_en, mem_rd_en, if_ack, ld_ack, ld_active}), 32'h0);
        @(negedge clk);
        rst = 1'b0; man_ack = 1'b1;
        #1;
        chk("rst_late_ack acks", 32'({if_ack, ld_ack}), 32'h0);
        chk("rst_late_ack state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        man_ack = 1'b0; ram_hold = 1'b0;

        // randomized traffic
        do_reset();
        ram_clear();
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        random_run(800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
